// File: rtl/usart_tx_feeder.sv
// USART transmit front end: byte FIFO, serial clock divider and a
// frame-slot scheduler that launches one byte per 16 serial periods.
module usart_tx_feeder #(
  parameter int CLOCK_DIV  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          serial_clock,
  output logic [7:0]                    tx_data,
  output logic                          tx_enable
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DW   = $clog2(CLOCK_DIV);
  localparam int HALF = CLOCK_DIV / 2;

  typedef enum logic [1:0] {
    IDLE,
    ENABLE,
    HOLD
  } state_t;

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          w_fall;
  logic          r_sclk;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_slot;
  logic [3:0]    w_slot_nxt;
  logic          r_en;
  logic          w_en_nxt;
  logic          w_try;
  logic          w_launch;
  logic [7:0]    r_data;

  assign w_div_nxt = (r_div == DW'(CLOCK_DIV - 1)) ? '0
                                                   : r_div + DW'(1);
  // The edge that returns the divider to zero is the serial fall.
  assign w_fall    = (r_div == DW'(CLOCK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_sclk <= (w_div_nxt >= DW'(HALF));
    end
  end

  assign wr_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_push   = wr_valid & wr_ready;
  assign w_pop    = w_launch;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_en_nxt    = r_en;
    w_try       = 1'b0;
    w_launch    = 1'b0;
    if (w_fall) begin
      unique case (r_state)
        IDLE: begin
          w_try = 1'b1;
        end
        ENABLE: begin
          w_en_nxt    = 1'b0;
          w_slot_nxt  = 4'd1;
          w_state_nxt = HOLD;
        end
        HOLD: begin
          if (r_slot == 4'd15) begin
            w_try = 1'b1;
          end else begin
            w_slot_nxt = r_slot + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    // Last slot falls straight into the idle decision on the same edge.
    if (w_try) begin
      if (r_count != '0) begin
        w_launch    = 1'b1;
        w_en_nxt    = 1'b1;
        w_slot_nxt  = 4'd0;
        w_state_nxt = ENABLE;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= HOLD;
      r_slot  <= 4'd0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_en    <= w_en_nxt;
      if (w_launch) begin
        r_data <= r_mem[r_rd];
      end
    end
  end

  assign fifo_count   = r_count;
  assign busy         = (r_state != IDLE);
  assign serial_clock = r_sclk;
  assign tx_data      = r_data;
  assign tx_enable    = r_en;

endmodule

// File: tb/tb_usart_tx_feeder.sv
// Directed bench for usart_tx_feeder with CLOCK_DIV=4, FIFO_DEPTH=4.
// Launch times are counted in clock edges since the last reset release.
module tb_usart_tx_feeder;

  logic       clock;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       serial_clock;
  logic [7:0] tx_data;
  logic       tx_enable;

  int checks;
  int failures;
  int cyc;

  usart_tx_feeder #(
    .CLOCK_DIV  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .serial_clock (serial_clock),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_launch(input int lim, output int t);
    logic prev;
    prev = tx_enable;
    t = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (tx_enable && !prev) begin
        t = cyc;
        break;
      end
      prev = tx_enable;
    end
  endtask

  initial begin
    int t;
    int t0;
    int n;
    int acc;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tick();
    tick();
    check("rst_sclk", int'(serial_clock), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_en", int'(tx_enable), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(wr_ready), 1);

    reset_n = 1'b1;
    cyc = 0;
    tick();
    check("sclk_c1", int'(serial_clock), 0);
    tick();
    check("sclk_c2", int'(serial_clock), 1);
    tick();
    check("sclk_c3", int'(serial_clock), 1);
    tick();
    check("sclk_c4", int'(serial_clock), 0);
    tick();
    tick();
    check("sclk_c6", int'(serial_clock), 1);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        t = cyc;
        break;
      end
      tick();
    end
    check("idle_at", t, 64);

    push(8'h55);
    check("cnt_55", int'(fifo_count), 1);
    wait_launch(20, t);
    check("launch_55", t, 68);
    check("data_55", int'(tx_data), 8'h55);
    check("cnt_pop55", int'(fifo_count), 0);
    n = 0;
    while (tx_enable && n < 20) begin
      n++;
      tick();
    end
    check("en_width", n, 4);

    push(8'h01);
    push(8'h80);
    push(8'hFF);
    check("cnt_3", int'(fifo_count), 3);
    wait_launch(200, t);
    check("launch_01", t, 132);
    check("data_01", int'(tx_data), 8'h01);
    t0 = t;
    wait_launch(200, t);
    check("gap_80", t - t0, 64);
    check("data_80", int'(tx_data), 8'h80);
    t0 = t;
    wait_launch(200, t);
    check("gap_ff", t - t0, 64);
    check("data_ff", int'(tx_data), 8'hFF);
    check("cnt_empty", int'(fifo_count), 0);

    acc = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'hA0 + 8'(i);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    check("full_acc", acc, 4);
    check("full_cnt", int'(fifo_count), 4);
    check("full_ready", int'(wr_ready), 0);

    wait_launch(200, t);
    check("launch_a0", t, 324);
    check("data_a0", int'(tx_data), 8'hA0);
    check("ready_back", int'(wr_ready), 1);
    wait_launch(200, t);
    check("data_a1", int'(tx_data), 8'hA1);
    check("cnt_a1", int'(fifo_count), 2);
    t0 = t + 64;
    for (int i = 0; i < 200 && cyc < t0 - 1; i++) tick();
    push(8'hB0);
    check("pp_cyc", cyc, t0);
    check("pp_en", int'(tx_enable), 1);
    check("pp_data", int'(tx_data), 8'hA2);
    check("pp_cnt", int'(fifo_count), 2);
    wait_launch(200, t);
    check("data_a3", int'(tx_data), 8'hA3);
    check("cnt_a3", int'(fifo_count), 1);

    push(8'hC0);
    push(8'hC1);
    check("cnt_pre_rst", int'(fifo_count), 3);
    reset_n = 1'b0;
    tick();
    check("mrst_cnt", int'(fifo_count), 0);
    check("mrst_en", int'(tx_enable), 0);
    check("mrst_busy", int'(busy), 1);
    reset_n = 1'b1;
    cyc = 0;
    push(8'hD5);
    check("post_cnt", int'(fifo_count), 1);
    wait_launch(200, t);
    check("post_launch", t, 64);
    check("post_data", int'(tx_data), 8'hD5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usart_tx_feeder.md
# usart_tx_feeder

Byte-queueing front end for the USART transmitter. It accepts bytes from the system bus side through a valid/ready write port and buffers them in a FIFO. It generates the transmitter's `serial_clock` from `clock` and launches one frame at a time by presenting `tx_data` and a single-period `tx_enable` pulse. Frame launches are spaced so the downstream transmitter (2-flop enable synchroniser, 10-bit frame, serial-clock domain) sees exactly one load per byte and is idle at every launch.

## Interface
- `CLOCK_DIV`, default 16: `clock` cycles per `serial_clock` period; even, ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO depth; power of 2, ≥ 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  **synchronous, active-low** reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_valid`  in  1  `wr_data` valid.
- `wr_ready`  out  1  FIFO can accept; `wr_ready = (fifo_count < FIFO_DEPTH)`, from registered count.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- `busy`  out  1  scheduler not in IDLE.
- `serial_clock`  out  1  baud clock to transmitter.
- `tx_data`  out  8  byte for transmitter; held stable between launches.
- `tx_enable`  out  1  launch pulse to transmitter.

## Operation
- Reset values (while `reset_n`=0 at a clock edge):
  - `div_count`=0, `serial_clock`=0, `tx_enable`=0, `tx_data`=0x00.
  - FIFO empty, `fifo_count`=0, `wr_ready`=1.
  - state=HOLD, `slot`=0, `busy`=1.
- Divider: `div_count` counts 0..CLOCK_DIV-1 and wraps.
  - `serial_clock` <= 1 when the next `div_count` ≥ CLOCK_DIV/2, else 0.
  - Rise when `div_count` becomes CLOCK_DIV/2; fall ("fall event") when it becomes 0.
- FIFO:
  - Push when `wr_valid & wr_ready`; pop when the scheduler launches.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Pop is only taken when `fifo_count`>0 before the edge, so a byte pushed into an empty FIFO is not popped in the same cycle.
  - Writes while full are not accepted, since `wr_ready`=0 whenever `fifo_count`=FIFO_DEPTH.
- Scheduler: acts only on fall events; all other cycles hold state.
  - IDLE: if `fifo_count`>0, pop head into `tx_data`, `tx_enable`<=1, `slot`<=0, go to ENABLE. Else stay.
  - ENABLE: `tx_enable`<=0, `slot`<=1, go to HOLD.
  - HOLD with `slot`<15: `slot`<=`slot`+1.
  - HOLD with `slot`=15: behave exactly as IDLE on this same fall event. It launches if non-empty, else goes to IDLE.
- `busy` = (state != IDLE).
- Frame slot is 16 `serial_clock` periods per byte; back-to-back bytes launch every 16 periods.
  - The transmitter needs 15: sample, sync, load, 10 shifts, clear.
- `tx_enable` spans exactly one rising edge of `serial_clock`, so the transmitter loads once per pulse.
- Reset mid-frame: all state is cleared and queued bytes are lost. The transmitter has no reset and finishes any frame in flight. The HOLD/`slot`=0 reset state delays the first launch by a full slot so that frame is never overlapped.

## Timing
- Launch updates (`tx_data`, `tx_enable`) occur on `serial_clock` falling edges, giving CLOCK_DIV/2 cycles of setup to the next rise.
- `tx_enable` high for exactly CLOCK_DIV `clock` cycles per launch.
- `tx_data` changes only on the launch edge and is otherwise held indefinitely.
- First launch after reset release: at fall event 16, i.e. 16·CLOCK_DIV cycles after release, if a byte is queued.
- Idle launch latency: push at cycle t gives `fifo_count` update at t+1 and launch at the first fall event after t+1 (≤ CLOCK_DIV cycles).
- `wr_ready` deasserts on the edge where the push makes `fifo_count`=FIFO_DEPTH. It reasserts on the edge after a pop.

## Test plan
- Reset with CLOCK_DIV=4: `serial_clock` first rises 2 cycles after release and then has period 4 cycles at 50% duty. `busy`=1, `tx_enable`=0, `tx_data`=0x00. `busy` drops at fall event 16 with no writes pending.
- After `busy`=0, write 0x55: `tx_data`=0x55 and `tx_enable` high for exactly 4 cycles from the next fall event. With a transmitter attached, `tx_pin` reads 0,1,0,1,0,1,0,1,0,1 on successive serial periods, then stays 1.
- Write 0x01, 0x80, 0xFF back-to-back: the three launches are spaced exactly 64 cycles (16 periods) apart. The receiver-side bit stream decodes to 0x01, 0x80, 0xFF with no extra frames.
- With FIFO_DEPTH=4, hold `wr_valid`=1 with 0xA0..0xA7 while stalled in HOLD: exactly 4 accepted, `fifo_count`=4, `wr_ready`=0. The byte stream order is preserved across wrap-around.
- Push on the same cycle as a launch pop with `fifo_count`=2: `fifo_count` stays 2.
- Assert `reset_n`=0 for 1 cycle mid-frame with 3 bytes queued: `fifo_count`=0 and `tx_enable`=0. No launch occurs for 16 serial periods, and the in-flight frame on `tx_pin` completes intact.
